rob_nway: RTL

Parametrised reorder buffer for the out-of-order core. It is the next generation of the fixed 32-entry, 3-completion-port ROB. It sits between dispatch, which allocates entries, and the commit interface, which returns old physical registers to rename. It generalises depth, completion-port count and commit width, and adds multi-wide in-order retirement and precise tail rollback on branch mispredict.

---
 rtl/rob_pkg.sv | 22 ++
 rtl/rob_retire_sel.sv | 31 +++
 rtl/rob_nway.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared types and helpers for the parametrised reorder buffer.
package rob_pkg;

  // Physical register fields are stored at this width and truncated to PREG_W at the ports.
  localparam int unsigned ROB_PREG_W_MAX = 16;

  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      has_dest;
    logic [ROB_PREG_W_MAX-1:0] pd_new;
    logic [ROB_PREG_W_MAX-1:0] pd_old;
  } rob_entry_t;

  // Age of to_tag relative to from_tag in a circular buffer of power-of-two depth.
  function automatic int unsigned tag_dist(input int unsigned from_tag,
                                           input int unsigned to_tag,
                                           input int unsigned depth);
    return (to_tag - from_tag) & (depth - 1);
  endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// In-order retire scan: walks COMMIT_W entries from head and stops at the first not-ready one.
module rob_retire_sel
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned TAG_W    = $clog2(DEPTH)
) (
  input  logic [TAG_W-1:0]    head_i,
  input  logic [DEPTH-1:0]    ready_i,
  output logic [COMMIT_W-1:0] retire_valid_o,
  output logic [TAG_W:0]      retire_cnt_o
);

  logic             run;
  logic [TAG_W-1:0] idx;

  always_comb begin
    retire_valid_o = '0;
    retire_cnt_o   = '0;
    run            = 1'b1;
    idx            = head_i;
    for (int unsigned l = 0; l < COMMIT_W; l++) begin
      idx               = head_i + TAG_W'(l);
      run               = run & ready_i[idx];
      retire_valid_o[l] = run;
      if (run) retire_cnt_o = retire_cnt_o + (TAG_W+1)'(1);
    end
  end

endmodule

// File: rtl/rob_nway.sv
// Parametrised reorder buffer with multi-wide retirement and tail rollback on mispredict.
// Optional per-entry PC storage and retire_pc port under ROB_RETIRE_PC_EN.
module rob_nway
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_CDB  = 3,
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned PREG_W   = 7,
  parameter int unsigned TAG_W    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write_en,
  input  logic                         has_dest_in,
  input  logic [PREG_W-1:0]            pd_new_in,
  input  logic [PREG_W-1:0]            pd_old_in,
  input  logic [31:0]                  pc_in,
  output logic [TAG_W-1:0]             ptr,
  output logic                         full,
  output logic [TAG_W:0]               count,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag,
  input  logic                         br_mispredict,
  input  logic [TAG_W-1:0]             br_mispredict_tag,
  output logic                         mispredict,
  output logic [TAG_W-1:0]             mispredict_tag,
  output logic [COMMIT_W-1:0]          retire_valid,
  output logic [COMMIT_W-1:0]          retire_has_dest,
  output logic [COMMIT_W*PREG_W-1:0]   retire_pd_old
`ifdef ROB_RETIRE_PC_EN
  ,output logic [COMMIT_W*32-1:0]      retire_pc
`endif
);

  rob_entry_t       rob_q [DEPTH];
  rob_entry_t       rob_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             mispredict_q;
  logic [TAG_W-1:0] mispredict_tag_q;

  logic             mp_hit, alloc;
  logic [DEPTH-1:0] younger, ready;
  int unsigned      br_dist;
  logic [TAG_W:0]   retire_cnt;
  logic [COMMIT_W-1:0] rv;
  logic [TAG_W-1:0] cdb_t, idx_r, idx_l;
  logic             unused_bits;

  assign ptr            = tail_q;
  assign count          = count_q;
  assign full           = (count_q == (TAG_W+1)'(DEPTH));
  assign mispredict     = mispredict_q;
  assign mispredict_tag = mispredict_tag_q;
  assign retire_valid   = rv;

  assign mp_hit = br_mispredict && rob_q[br_mispredict_tag].valid;
  assign alloc  = write_en && !full && !br_mispredict;

  // Entries younger than a mispredicting branch may not retire, so the rolled-back count stays exact.
  always_comb begin
    younger = '0;
    ready   = '0;
    br_dist = tag_dist(32'(head_q), 32'(br_mispredict_tag), DEPTH);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      younger[i] = mp_hit && (tag_dist(32'(head_q), i, DEPTH) > br_dist);
      ready[i]   = rob_q[i].valid && rob_q[i].done && !younger[i];
    end
  end

  rob_retire_sel #(
    .DEPTH    (DEPTH),
    .COMMIT_W (COMMIT_W),
    .TAG_W    (TAG_W)
  ) u_retire_sel (
    .head_i         (head_q),
    .ready_i        (ready),
    .retire_valid_o (rv),
    .retire_cnt_o   (retire_cnt)
  );

  always_comb begin
    rob_d   = rob_q;
    head_d  = head_q + retire_cnt[TAG_W-1:0];
    tail_d  = tail_q;
    count_d = count_q + (TAG_W+1)'(alloc) - retire_cnt;
    cdb_t   = '0;
    idx_r   = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      cdb_t = cdb_tag[k*TAG_W +: TAG_W];
      if (cdb_valid[k] && rob_q[cdb_t].valid && !younger[cdb_t]) rob_d[cdb_t].done = 1'b1;
    end
    for (int unsigned l = 0; l < COMMIT_W; l++) begin
      idx_r = head_q + TAG_W'(l);
      if (rv[l]) begin
        rob_d[idx_r].valid = 1'b0;
        rob_d[idx_r].done  = 1'b0;
      end
    end
    if (mp_hit) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (younger[i]) begin
          rob_d[i].valid = 1'b0;
          rob_d[i].done  = 1'b0;
        end
      end
      rob_d[br_mispredict_tag].done = 1'b1;
      tail_d  = br_mispredict_tag + TAG_W'(1);
      count_d = (TAG_W+1)'(br_dist + 1) - retire_cnt;
    end else if (alloc) begin
      rob_d[tail_q].valid    = 1'b1;
      rob_d[tail_q].done     = 1'b0;
      rob_d[tail_q].has_dest = has_dest_in;
      rob_d[tail_q].pd_new   = ROB_PREG_W_MAX'(pd_new_in);
      rob_d[tail_q].pd_old   = ROB_PREG_W_MAX'(pd_old_in);
      tail_d = tail_q + TAG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      mispredict_q     <= 1'b0;
      mispredict_tag_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) rob_q[i] <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      mispredict_q <= mp_hit;
      if (mp_hit) mispredict_tag_q <= br_mispredict_tag;
      for (int unsigned i = 0; i < DEPTH; i++) rob_q[i] <= rob_d[i];
    end
  end

  always_comb begin
    retire_has_dest = '0;
    retire_pd_old   = '0;
    idx_l           = '0;
    for (int unsigned l = 0; l < COMMIT_W; l++) begin
      idx_l = head_q + TAG_W'(l);
      retire_has_dest[l]                 = rv[l] & rob_q[idx_l].has_dest;
      retire_pd_old[l*PREG_W +: PREG_W]  = rob_q[idx_l].pd_old[PREG_W-1:0];
    end
  end

`ifdef ROB_RETIRE_PC_EN
  logic [31:0]      pc_q [DEPTH];
  logic [TAG_W-1:0] idx_pc;

  always_ff @(posedge clk) begin
    if (alloc) pc_q[tail_q] <= pc_in;
  end

  always_comb begin
    retire_pc = '0;
    idx_pc    = '0;
    for (int unsigned l = 0; l < COMMIT_W; l++) begin
      idx_pc = head_q + TAG_W'(l);
      retire_pc[l*32 +: 32] = pc_q[idx_pc];
    end
  end
`endif

  always_comb begin
    unused_bits = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++)
      unused_bits = unused_bits ^ (^rob_q[i].pd_new) ^ (^rob_q[i].pd_old);
`ifndef ROB_RETIRE_PC_EN
    unused_bits = unused_bits ^ (^pc_in);
`endif
  end

endmodule
